// File: rtl/int_to_float_pipe.sv
// int_to_float_pipe: signed/unsigned INT_WIDTH-bit integer to IEEE-754 Float32 converter.
// Latency 3 cycles (S1 magnitude, S2 leading-one + normalise, S3 round/pack), 1 result per cycle.
// Backpressure: valid/ready; each stage holds when its successor stalls, at most 3 items in flight.
// Optional macro ITOF_ROUND_NEAREST_EN selects round-to-nearest-even; without it S3 truncates toward zero.
module int_to_float_pipe #(
  parameter int INT_WIDTH = 32
) (
  input  logic                 aClock,
  input  logic                 aResetN,
  input  logic                 anInValid,
  output logic                 anInReady,
  input  logic [INT_WIDTH-1:0] anInput,
  input  logic                 aSigned,
  output logic                 anOutValid,
  input  logic                 anOutReady,
  output logic [31:0]          anOutput,
  output logic                 anInexact
);

  // One extra magnitude bit so the most negative signed operand has a positive magnitude.
  localparam int MAG_W  = INT_WIDTH + 1;
  // Normalised vector: leading one, 23 mantissa bits, guard, round, then MAG_W sticky bits.
  localparam int NORM_W = MAG_W + 26;
  // Wide enough for a leading-one index / shift amount up to 64.
  localparam int K_W    = 7;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic             s1_vld;
  logic             s1_sign;
  logic [MAG_W-1:0] s1_mag;

  logic             s2_vld;
  logic             s2_sign;
  logic [7:0]       s2_exp;
  logic [22:0]      s2_man;
  logic             s2_guard;
  logic             s2_round;
  logic             s2_sticky;

  // ---------------------------------------------------------------------------
  // Handshake: a stage loads when empty or when its contents move on this cycle
  // ---------------------------------------------------------------------------
  logic load_s1;
  logic load_s2;
  logic load_s3;

  assign load_s3   = s2_vld && (!anOutValid || anOutReady);
  assign load_s2   = s1_vld && (!s2_vld || load_s3);
  assign anInReady = !s1_vld || load_s2;
  assign load_s1   = anInValid && anInReady;

  // ---------------------------------------------------------------------------
  // S1: sign and absolute value
  // ---------------------------------------------------------------------------
  logic             neg_c;
  logic [MAG_W-1:0] ext_op;
  logic [MAG_W-1:0] mag_c;

  // Sign-extend negative signed operands by one bit, then negate to get the magnitude.
  always_comb begin
    neg_c  = aSigned && anInput[INT_WIDTH-1];
    ext_op = {neg_c, anInput};
    mag_c  = neg_c ? (~ext_op + MAG_W'(1)) : ext_op;
  end

  // S1 register: capture sign and magnitude on input transfer, empty when S2 takes the item.
  always_ff @(posedge aClock or negedge aResetN) begin
    if (!aResetN) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
    end else begin
      if (load_s1) begin
        s1_vld  <= 1'b1;
        s1_sign <= neg_c;
        s1_mag  <= mag_c;
      end else if (load_s2) begin
        s1_vld <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: leading-one detect and left-normalise
  // ---------------------------------------------------------------------------
  logic [K_W-1:0]    lead_k;
  logic [K_W-1:0]    shamt;
  logic [NORM_W-1:0] norm;
  logic              nz_c;
  logic [7:0]        exp_c;
  logic [22:0]       man_c;
  logic              guard_c;
  logic              round_c;
  logic              sticky_c;

  // Find the highest set bit, shift it to the top, and slice mantissa/guard/round/sticky.
  always_comb begin
    lead_k = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (s1_mag[i]) begin
        lead_k = K_W'(i);
      end
    end
    shamt    = K_W'(MAG_W - 1) - lead_k;
    norm     = {s1_mag, 26'b0} << shamt;
    // After normalising, the top bit is set exactly when the magnitude is nonzero.
    nz_c     = norm[NORM_W-1];
    man_c    = norm[NORM_W-2 -: 23];
    guard_c  = norm[NORM_W-25];
    round_c  = norm[NORM_W-26];
    sticky_c = |norm[NORM_W-27:0];
    exp_c    = nz_c ? (8'd127 + {1'b0, lead_k}) : 8'd0;
  end

  // S2 register: hold normalised fields; a zero operand is forced to +0.
  always_ff @(posedge aClock or negedge aResetN) begin
    if (!aResetN) begin
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_exp    <= 8'd0;
      s2_man    <= 23'd0;
      s2_guard  <= 1'b0;
      s2_round  <= 1'b0;
      s2_sticky <= 1'b0;
    end else begin
      if (load_s2) begin
        s2_vld    <= 1'b1;
        s2_sign   <= s1_sign && nz_c;
        s2_exp    <= exp_c;
        s2_man    <= man_c;
        s2_guard  <= guard_c;
        s2_round  <= round_c;
        s2_sticky <= sticky_c;
      end else if (load_s3) begin
        s2_vld <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: round and pack
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_r;
  logic [22:0] man_r;
  logic        inexact_r;

`ifdef ITOF_ROUND_NEAREST_EN
  logic        round_up;
  logic [23:0] man_sum;

  // Round to nearest, ties to even; a carry out of the mantissa bumps the exponent.
  always_comb begin
    inexact_r = s2_guard | s2_round | s2_sticky;
    round_up  = s2_guard && (s2_round || s2_sticky || s2_man[0]);
    man_sum   = {1'b0, s2_man} + {23'd0, round_up};
    if (man_sum[23]) begin
      man_r = 23'd0;
      exp_r = s2_exp + 8'd1;
    end else begin
      man_r = man_sum[22:0];
      exp_r = s2_exp;
    end
  end
`else
  // Truncate toward zero: keep the mantissa as is, still flag dropped bits.
  always_comb begin
    inexact_r = s2_guard | s2_round | s2_sticky;
    man_r     = s2_man;
    exp_r     = s2_exp;
  end
`endif

  // Output register: load a new result when free or draining, otherwise hold steady.
  always_ff @(posedge aClock or negedge aResetN) begin
    if (!aResetN) begin
      anOutValid <= 1'b0;
      anOutput   <= 32'h0000_0000;
      anInexact  <= 1'b0;
    end else begin
      if (load_s3) begin
        anOutValid <= 1'b1;
        anOutput   <= {s2_sign, exp_r, man_r};
        anInexact  <= inexact_r;
      end else if (anOutReady) begin
        anOutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// tb_int_to_float_pipe: scoreboard bench for int_to_float_pipe (INT_WIDTH=32).
// Directed vectors use fixed expected constants; random traffic uses an IEEE reference
// built from real arithmetic. Honours ITOF_ROUND_NEAREST_EN like the design.
module tb_int_to_float_pipe;

  localparam int W = 32;

  logic          aClock = 1'b0;
  logic          aResetN;
  logic          anInValid;
  logic          anInReady;
  logic [W-1:0]  anInput;
  logic          aSigned;
  logic          anOutValid;
  logic          anOutReady;
  logic [31:0]   anOutput;
  logic          anInexact;

  int_to_float_pipe #(.INT_WIDTH(W)) dut (
    .aClock     (aClock),
    .aResetN    (aResetN),
    .anInValid  (anInValid),
    .anInReady  (anInReady),
    .anInput    (anInput),
    .aSigned    (aSigned),
    .anOutValid (anOutValid),
    .anOutReady (anOutReady),
    .anOutput   (anOutput),
    .anInexact  (anInexact)
  );

  always #5 aClock = ~aClock;

  int cyc = 0;
  always @(posedge aClock) cyc++;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    int          in_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact value -> double (exact for 32-bit ints) -> Float32 by IEEE rules.
  function automatic void ref_conv(input logic [31:0] x, input logic sgn,
                                   output logic [31:0] r, output logic ix);
    longint      v;
    longint      mag;
    real         rv;
    logic [63:0] db;
    int          fe;
    logic [28:0] rest;
    longint      m24;
    v   = sgn ? longint'($signed(x)) : longint'({32'b0, x});
    mag = (v < 0) ? -v : v;
    r   = 32'h0;
    ix  = 1'b0;
    if (mag != 0) begin
      rv   = real'(mag);
      db   = $realtobits(rv);
      fe   = int'(db[62:52]) - 1023 + 127;
      m24  = longint'({1'b1, db[51:29]});
      rest = db[28:0];
      ix   = (rest != 0);
`ifdef ITOF_ROUND_NEAREST_EN
      if (rest[28] && ((rest[27:0] != 0) || m24[0])) m24 = m24 + 1;
      if (m24 == (longint'(1) << 24)) begin
        m24 = m24 >> 1;
        fe  = fe + 1;
      end
`endif
      r = {(v < 0), fe[7:0], m24[22:0]};
    end
  endfunction

  // Monitor: pops the scoreboard on each output transfer and checks stall stability.
  logic        held_vld = 1'b0;
  logic [31:0] held_out;
  logic        held_inx;
  always @(negedge aClock) begin
    if (!aResetN) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check("hold_valid", 64'(anOutValid), 64'd1);
        check("hold_output", 64'(anOutput), 64'(held_out));
        check("hold_inexact", 64'(anInexact), 64'(held_inx));
      end
      if (anOutValid && anOutReady) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h expected none", anOutput);
        end else begin
          mon_e = sb.pop_front();
          check("result", 64'(anOutput), 64'(mon_e.res));
          check("inexact", 64'(anInexact), 64'(mon_e.inx));
          if (mon_e.chk_lat) check("latency", 64'(cyc + 1 - mon_e.in_cyc), 64'd3);
        end
      end
      held_vld = anOutValid && !anOutReady;
      held_out = anOutput;
      held_inx = anInexact;
    end
  end

  // Present one operand (called just after a rising edge); push its expectation on transfer.
  task automatic send(input logic [31:0] x, input logic sgn, input logic [31:0] r,
                      input logic ix, input bit lat);
    exp_t e;
    int   waitc;
    bit   done;
    waitc     = 0;
    done      = 0;
    anInValid = 1'b1;
    anInput   = x;
    aSigned   = sgn;
    while (!done) begin
      @(negedge aClock);
      if (anInReady) begin
        e.res     = r;
        e.inx     = ix;
        e.in_cyc  = cyc + 1;
        e.chk_lat = lat;
        sb.push_back(e);
        done = 1;
      end else begin
        waitc++;
        if (waitc > 200) begin
          total++;
          bad++;
          $display("FAIL in_ready_timeout: got ready=0 for %0d cycles expected ready", waitc);
          done = 1;
        end
      end
      @(posedge aClock);
      #1;
    end
    anInValid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] x, input logic sgn, input bit lat);
    logic [31:0] r;
    logic        ix;
    ref_conv(x, sgn, r, ix);
    send(x, sgn, r, ix, lat);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge aClock);
      n++;
    end
    @(posedge aClock);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
  endtask

  bit rnd_done = 0;

  initial begin
    aResetN    = 1'b1;
    anInValid  = 1'b0;
    anInput    = '0;
    aSigned    = 1'b0;
    anOutReady = 1'b1;
    #2 aResetN = 1'b0;
    #1;
    check("reset_out_valid", 64'(anOutValid), 64'd0);
    check("reset_output", 64'(anOutput), 64'd0);
    check("reset_inexact", 64'(anInexact), 64'd0);
    repeat (3) @(posedge aClock);
    #3 aResetN = 1'b1;
    @(negedge aClock);
    check("ready_after_reset", 64'(anInReady), 64'd1);
    @(posedge aClock);
    #1;

    // Unsigned exact values, back-to-back, latency checked.
    send(32'd0,          1'b0, 32'h0000_0000, 1'b0, 1);
    send(32'd1,          1'b0, 32'h3F80_0000, 1'b0, 1);
    send(32'd5,          1'b0, 32'h40A0_0000, 1'b0, 1);
    send(32'h00FF_FFFF,  1'b0, 32'h4B7F_FFFF, 1'b0, 1);
    // Signed and extreme values.
    send(32'hFFFF_FFFF,  1'b1, 32'hBF80_0000, 1'b0, 1);
    send(32'h8000_0000,  1'b1, 32'hCF00_0000, 1'b0, 1);
    send(32'h8000_0000,  1'b0, 32'h4F00_0000, 1'b0, 1);
    // Inexact values: rounding-mode dependent.
`ifdef ITOF_ROUND_NEAREST_EN
    send(32'd16777217,   1'b0, 32'h4B80_0000, 1'b1, 1);
    send(32'd16777219,   1'b0, 32'h4B80_0002, 1'b1, 1);
    send(32'hFFFF_FFFF,  1'b0, 32'h4F80_0000, 1'b1, 1);
`else
    send(32'd16777217,   1'b0, 32'h4B80_0000, 1'b1, 1);
    send(32'd16777219,   1'b0, 32'h4B80_0001, 1'b1, 1);
    send(32'hFFFF_FFFF,  1'b0, 32'h4F7F_FFFF, 1'b1, 1);
`endif
    wait_empty();

    // Backpressure: consumer stalls for 5 cycles while 6 items stream in.
    anOutReady = 1'b0;
    for (int i = 0; i < 3; i++) send_model(32'(1000 * (i + 1) + $urandom_range(0, 999)), 1'(i & 1), 0);
    @(negedge aClock);
    check("in_ready_full", 64'(anInReady), 64'd0);
    @(posedge aClock);
    #1;
    @(negedge aClock);
    @(posedge aClock);
    #1;
    anOutReady = 1'b1;
    for (int i = 3; i < 6; i++) send_model(32'(1000 * (i + 1) + $urandom_range(0, 999)), 1'(i & 1), 0);
    wait_empty();

    // Reset with two results in flight.
    anOutReady = 1'b0;
    send_model(32'd123456, 1'b0, 0);
    send_model(32'hFFFF_0000, 1'b1, 0);
    @(posedge aClock);
    #1;
    check("pre_reset_valid", 64'(anOutValid), 64'd1);
    aResetN = 1'b0;
    #1;
    sb.delete();
    check("midreset_out_valid", 64'(anOutValid), 64'd0);
    check("midreset_output", 64'(anOutput), 64'd0);
    check("midreset_inexact", 64'(anInexact), 64'd0);
    repeat (2) @(posedge aClock);
    #3;
    aResetN    = 1'b1;
    anOutReady = 1'b1;
    @(negedge aClock);
    check("ready_after_midreset", 64'(anInReady), 64'd1);
    @(posedge aClock);
    #1;
    send(32'd7, 1'b0, 32'h40E0_0000, 1'b0, 1);
    wait_empty();

    // Random traffic with random gaps and random consumer stalls.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [31:0] x;
          x = $urandom >> $urandom_range(0, 31);
          if ($urandom_range(0, 15) == 0) x = 32'h8000_0000;
          if ($urandom_range(0, 31) == 0) x = 32'h0;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge aClock);
            #1;
          end
          send_model(x, 1'($urandom_range(0, 1)), 0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge aClock);
          #1;
          anOutReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    anOutReady = 1'b1;
    wait_empty();
    repeat (5) @(posedge aClock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
